// File: rtl/sched_pkg.sv
// Shared types and default sizing for the per-channel FIFO read scheduler.
// The state encoding is kept here so that the bench and the top agree on it.
package sched_pkg;

   localparam int N_CH_DEF      = 80;
   localparam int CHID_W_DEF    = 7;
   localparam int BURST_MAX_DEF = 4;

   typedef logic [CHID_W_DEF-1:0] chid_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      READ = 2'd2
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: the first requesting index at or after ptr, wrapping modulo N_CH.
// Implemented as a find-first over the doubled request vector, with entries below ptr masked off.
module rr_pick #(
   parameter int N_CH   = 80,
   parameter int CHID_W = 7
) (
   input  logic [N_CH-1:0]   req,
   input  logic [CHID_W-1:0] ptr,
   output logic [CHID_W-1:0] pick,
   output logic              any_req
);

   logic found;

   // NOTE: always_comb uses blocking assignments, and every output gets a default first, so no latch is inferred.
   always_comb begin
      pick    = '0;
      found   = 1'b0;
      any_req = |req;
      for (int j = 0; j < 2 * N_CH; j++) begin
         if (!found && (j >= int'(ptr)) && req[j % N_CH]) begin
            found = 1'b1;
            pick  = CHID_W'(j % N_CH);
         end
      end
   end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Work-conserving round-robin read scheduler for the per-channel output FIFOs.
// It issues bursts of up to BURST_MAX reads per grant and returns the channel id one cycle later.
module fifo_rr_scheduler
   import sched_pkg::*;
#(
   parameter int N_CH      = N_CH_DEF,
   parameter int CHID_W    = CHID_W_DEF,
   parameter int BURST_MAX = BURST_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic [N_CH-1:0]   fifo_empty,
   input  logic              out_ready,
   output logic [N_CH-1:0]   fifo_read_enable,
   output logic              rd_valid,
   output logic [CHID_W-1:0] rd_chid,
   output logic              busy
);

   state_t            state, state_nxt;
   logic [CHID_W-1:0] ptr, ptr_nxt;
   logic [CHID_W-1:0] grant, grant_nxt, grant_inc;
   logic [7:0]        burst_cnt, burst_cnt_nxt;
   logic [N_CH-1:0]   req;
   logic [CHID_W-1:0] pick;
   logic              any_req;
   logic              rd_go;
   logic              burst_done;

   assign req = ~fifo_empty;

   rr_pick #(
      .N_CH   (N_CH),
      .CHID_W (CHID_W)
   ) u_pick (
      .req     (req),
      .ptr     (ptr),
      .pick    (pick),
      .any_req (any_req)
   );

   assign grant_inc  = (grant == CHID_W'(N_CH - 1)) ? '0 : grant + 1'b1;
   assign burst_done = ((burst_cnt + {7'd0, rd_go}) == 8'(BURST_MAX));

   always_comb begin
      state_nxt        = state;
      ptr_nxt          = ptr;
      grant_nxt        = grant;
      burst_cnt_nxt    = burst_cnt;
      fifo_read_enable = '0;
      rd_go            = 1'b0;
      case (state)
         IDLE: begin
            if (start && !stop) state_nxt = ARB;
         end
         ARB: begin
            if (stop) begin
               state_nxt = IDLE;
            end else if (any_req) begin
               grant_nxt     = pick;
               burst_cnt_nxt = '0;
               state_nxt     = READ;
            end
         end
         READ: begin
            rd_go = out_ready & ~fifo_empty[grant] & ~stop;
            if (rd_go) begin
               fifo_read_enable[grant] = 1'b1;
               burst_cnt_nxt           = burst_cnt + 8'd1;
            end
            // Backpressure with data present falls through: hold READ, counter frozen.
            if (stop) begin
               state_nxt = IDLE;
               ptr_nxt   = grant_inc;
            end else if (fifo_empty[grant] || burst_done) begin
               state_nxt = ARB;
               ptr_nxt   = grant_inc;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         grant     <= '0;
         burst_cnt <= '0;
         rd_valid  <= 1'b0;
         rd_chid   <= '0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         grant     <= grant_nxt;
         burst_cnt <= burst_cnt_nxt;
         rd_valid  <= rd_go;
         rd_chid   <= grant;
         busy      <= (state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler with a behavioural FIFO occupancy model
// and a return-path scoreboard that runs every cycle.
module tb_fifo_rr_scheduler;
   import sched_pkg::*;

   localparam int N_CH = 80;

   logic            clk;
   logic            rst;
   logic            start;
   logic            stop;
   logic [N_CH-1:0] fifo_empty;
   logic            out_ready;
   logic [N_CH-1:0] fifo_read_enable;
   logic            rd_valid;
   logic [6:0]      rd_chid;
   logic            busy;

   int checks   = 0;
   int failures = 0;
   int cnt[N_CH];
   int rlog[$];
   int slog[$];
   int prev_rd  = -1;
   int rv_count = 0;
   int rd_count = 0;
   bit sb_on    = 1'b0;

   fifo_rr_scheduler dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .stop             (stop),
      .fifo_empty       (fifo_empty),
      .out_ready        (out_ready),
      .fifo_read_enable (fifo_read_enable),
      .rd_valid         (rd_valid),
      .rd_chid          (rd_chid),
      .busy             (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic refresh_empty();
      for (int i = 0; i < N_CH; i++) fifo_empty[i] = (cnt[i] == 0);
   endtask

   task automatic set_cnt(input int ch, input int n);
      cnt[ch] = n;
      refresh_empty();
   endtask

   // One clock cycle: inputs were set at the falling edge; sample, clock, update the FIFO model.
   task automatic cyc();
      int rd_ch;
      #1;
      rd_ch = -1;
      for (int i = 0; i < N_CH; i++) if (fifo_read_enable[i]) rd_ch = i;
      if (sb_on) begin
         check("fre_onehot", ($countones(fifo_read_enable) <= 1), 1);
         check("rd_valid", rd_valid, (prev_rd >= 0));
         if (prev_rd >= 0) check("rd_chid", rd_chid, prev_rd);
         if (rd_ch >= 0) check("rd_nonempty", (cnt[rd_ch] > 0), 1);
      end
      if (rd_valid === 1'b1) rv_count++;
      if (rd_ch >= 0) rd_count++;
      rlog.push_back(rd_ch);
      slog.push_back(int'(dut.state));
      prev_rd = rst ? -1 : rd_ch;
      @(posedge clk);
      #1;
      if (rd_ch >= 0 && cnt[rd_ch] > 0) cnt[rd_ch]--;
      refresh_empty();
      @(negedge clk);
   endtask

   task automatic clear_log();
      rlog.delete();
      slog.delete();
   endtask

   int exp_t1[6]  = '{-1, 5, 5, -1, -1, -1};
   int exp_t3[6]  = '{-1, 79, -1, -1, 0, -1};
   int exp_t4[10] = '{-1, 10, 10, -1, -1, -1, 10, 10, -1, -1};
   int exp_t5[6]  = '{-1, 12, 12, -1, -1, -1};
   int exp_gch[9] = '{3, 40, 79, 3, 40, 79, 3, 40, 79};
   int exp_gln[9] = '{4, 4, 4, 4, 4, 4, 2, 2, 2};

   initial begin
      int rv0, rd0, nreads, arb_gap;
      int bch[$];
      int blen[$];
      int garb[$];

      rst = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < N_CH; i++) cnt[i] = 0;
      refresh_empty();
      @(negedge clk);
      cyc();
      cyc();
      rst = 1'b0;
      sb_on = 1'b1;
      check("rst_busy", busy, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_chid", rd_chid, 0);
      check("rst_fre", (fifo_read_enable == '0), 1);
      check("rst_ptr", dut.ptr, 0);
      check("rst_state", int'(dut.state), int'(IDLE));

      // All empty: ARB polls without reading, then a 2-word channel 5 drains.
      start = 1'b1;
      cyc();
      start = 1'b0;
      check("t1_busy_c1", busy, 1);
      check("t1_state_arb", int'(dut.state), int'(ARB));
      clear_log();
      for (int k = 0; k < 50; k++) cyc();
      nreads = 0;
      foreach (rlog[k]) if (rlog[k] >= 0) nreads++;
      check("t1_idle_reads", nreads, 0);
      check("t1_busy_poll", busy, 1);
      set_cnt(5, 2);
      clear_log();
      rv0 = rv_count;
      for (int k = 0; k < 6; k++) cyc();
      for (int k = 0; k < 6; k++) check($sformatf("t1_rd%0d", k), rlog[k], exp_t1[k]);
      check("t1_rv", rv_count - rv0, 2);
      check("t1_ptr", dut.ptr, 6);

      // Three loaded channels, round-robin bursts of 4 then the 2-word tails.
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      set_cnt(3, 10); set_cnt(40, 10); set_cnt(79, 10);
      start = 1'b1;
      cyc();
      start = 1'b0;
      clear_log();
      rv0 = rv_count;
      rd0 = rd_count;
      for (int k = 0; k < 50; k++) cyc();
      arb_gap = 0;
      foreach (rlog[k]) begin
         if (rlog[k] >= 0) begin
            if (k > 0 && rlog[k-1] == rlog[k]) begin
               blen[blen.size()-1]++;
            end else begin
               if (bch.size() > 0) garb.push_back(arb_gap);
               bch.push_back(rlog[k]);
               blen.push_back(1);
               arb_gap = 0;
            end
         end else if (slog[k] == int'(ARB)) begin
            arb_gap++;
         end
      end
      check("t2_nbursts", bch.size(), 9);
      if (bch.size() == 9) begin
         for (int b = 0; b < 9; b++) begin
            check($sformatf("t2_grant%0d", b), bch[b], exp_gch[b]);
            check($sformatf("t2_len%0d", b), blen[b], exp_gln[b]);
         end
         for (int b = 0; b < 8; b++) check($sformatf("t2_bubble%0d", b), garb[b], 1);
      end
      check("t2_reads", rd_count - rd0, 30);
      check("t2_rv", rv_count - rv0, 30);
      check("t2_ptr", dut.ptr, 0);

      // Wrap-around from ptr 79.
      set_cnt(78, 1);
      for (int k = 0; k < 4; k++) cyc();
      check("t3_ptr79", dut.ptr, 79);
      set_cnt(79, 1); set_cnt(0, 1);
      clear_log();
      for (int k = 0; k < 3; k++) cyc();
      check("t3_ptr0", dut.ptr, 0);
      for (int k = 0; k < 3; k++) cyc();
      check("t3_ptr1", dut.ptr, 1);
      for (int k = 0; k < 6; k++) check($sformatf("t3_rd%0d", k), rlog[k], exp_t3[k]);

      // Backpressure for 3 cycles after 2 reads on channel 10.
      set_cnt(10, 4);
      clear_log();
      rv0 = rv_count;
      for (int k = 0; k < 3; k++) cyc();
      check("t4_bc_pre", dut.burst_cnt, 2);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         check($sformatf("t4_bc_hold%0d", k), dut.burst_cnt, 2);
         check($sformatf("t4_grant%0d", k), dut.grant, 10);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) cyc();
      for (int k = 0; k < 10; k++) check($sformatf("t4_rd%0d", k), rlog[k], exp_t4[k]);
      check("t4_rv", rv_count - rv0, 4);
      check("t4_cnt", cnt[10], 0);
      check("t4_ptr", dut.ptr, 11);

      // Stop after 2 reads on channel 12.
      set_cnt(12, 5);
      clear_log();
      rv0 = rv_count;
      for (int k = 0; k < 3; k++) cyc();
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      check("t5_state", int'(dut.state), int'(IDLE));
      check("t5_busy", busy, 0);
      check("t5_ptr", dut.ptr, 13);
      for (int k = 0; k < 2; k++) cyc();
      for (int k = 0; k < 6; k++) check($sformatf("t5_rd%0d", k), rlog[k], exp_t5[k]);
      check("t5_rv", rv_count - rv0, 2);
      check("t5_cnt", cnt[12], 3);
      start = 1'b1; stop = 1'b1;
      cyc();
      start = 1'b0; stop = 1'b0;
      check("t5_startstop_state", int'(dut.state), int'(IDLE));
      check("t5_startstop_busy", busy, 0);

      // Reset in the middle of a burst on channel 20.
      set_cnt(12, 0);
      set_cnt(20, 5); set_cnt(25, 3);
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      check("t6_state_read", int'(dut.state), int'(READ));
      check("t6_grant20", dut.grant, 20);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("t6_fre", (fifo_read_enable == '0), 1);
      check("t6_rd_valid", rd_valid, 0);
      check("t6_rd_chid", rd_chid, 0);
      check("t6_busy", busy, 0);
      check("t6_ptr", dut.ptr, 0);
      check("t6_grant0", dut.grant, 0);
      check("t6_bc", dut.burst_cnt, 0);
      check("t6_state", int'(dut.state), int'(IDLE));
      start = 1'b1;
      cyc();
      start = 1'b0;
      clear_log();
      for (int k = 0; k < 3; k++) cyc();
      check("t6_first_rd", rlog[1], 20);
      check("t6_regrant", dut.grant, 20);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      cyc();
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
